// File: rtl/dc_1_missctl_if.sv
// dc_1_missctl_if: tag-check, L2 request/ack/displacement and tag-bank fill signals of the miss controller
interface dc_1_missctl_if #(parameter int TAG_W = 10, parameter int IDX_W = 5, parameter int WAYS = 8, parameter int WW = $clog2(WAYS));
  logic miss_valid, miss_retry, miss_write;
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_index;
  logic [2*WAYS-1:0] set_rrip;
  logic [WAYS-1:0] set_dirty;
  logic l1tol2_req_valid, l1tol2_req_retry;
  logic [2:0] l1tol2_req;
  logic l2tol1_snack_valid;
  logic [4:0] l2tol1_snack;
  logic l1tol2_disp_valid, l1tol2_disp_retry;
  logic [2:0] l1tol2_disp;
  logic age_valid;
  logic [2*WAYS-1:0] age_rrip;
  logic fill_valid;
  logic [IDX_W-1:0] fill_index;
  logic [WW-1:0] fill_way;
  logic [TAG_W+4:0] fill_data;
  logic busy;
  modport master (
    input miss_valid, miss_write, miss_tag, miss_index, set_rrip, set_dirty,
          l1tol2_req_retry, l2tol1_snack_valid, l2tol1_snack, l1tol2_disp_retry,
    output miss_retry, l1tol2_req_valid, l1tol2_req, l1tol2_disp_valid, l1tol2_disp,
           age_valid, age_rrip, fill_valid, fill_index, fill_way, fill_data, busy
  );
  modport slave (
    output miss_valid, miss_write, miss_tag, miss_index, set_rrip, set_dirty,
           l1tol2_req_retry, l2tol1_snack_valid, l2tol1_snack, l1tol2_disp_retry,
    input miss_retry, l1tol2_req_valid, l1tol2_req, l1tol2_disp_valid, l1tol2_disp,
          age_valid, age_rrip, fill_valid, fill_index, fill_way, fill_data, busy
  );
endinterface

// File: rtl/dc_1_missctl.sv
// dc_1_missctl: single-MSHR L1 D-cache miss controller (L2 request, ack wait, RRIP victim, displacement, fill)
module dc_1_missctl #(
  parameter int TAG_W = 10,
  parameter int IDX_W = 5,
  parameter int WAYS = 8,
  parameter logic [1:0] RRIP_INS = 2'd2,
  parameter logic [2:0] DISP_CMD = 3'b001
) (
  input logic clk,
  input logic reset,
  dc_1_missctl_if.master m
);
  localparam int WW = $clog2(WAYS);
  localparam logic [2:0] REQ_S = 3'd1, REQ_M = 3'd2;
  localparam logic [4:0] ACK_S = 5'h04, ACK_E = 5'h05, ACK_M = 5'h06;
  localparam logic [2:0] ST_I = 3'd0, ST_S = 3'd1, ST_E = 3'd2, ST_M = 3'd3;
  typedef enum logic [2:0] {IDLE, REQ, WAIT_ACK, VICTIM, DISP, FILL} state_t;
  state_t state, nxt;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic wr_q, hit, leave, ack_ok;
  logic [2:0] st_q, ack_st;
  logic [WW-1:0] way_q, vw;
  logic [1:0] age_cnt;
  logic [2*WAYS-1:0] age_next;
  // descending scan so the lowest way holding a distant (3) counter wins
  always_comb begin
    hit = 1'b0;
    vw = '0;
    age_next = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (m.set_rrip[2*w+:2] == 2'd3) begin
        hit = 1'b1;
        vw = WW'(w);
      end
      age_next[2*w+:2] = (&m.set_rrip[2*w+:2]) ? 2'd3 : m.set_rrip[2*w+:2] + 2'd1;
    end
  end
  assign ack_st = m.l2tol1_snack == ACK_S ? ST_S : m.l2tol1_snack == ACK_E ? ST_E :
                  m.l2tol1_snack == ACK_M ? ST_M : ST_I;
  assign ack_ok = m.l2tol1_snack_valid && ack_st != ST_I;
  // three agings always saturate some counter; the count bound is only a safety exit to way 0
  assign leave = hit || age_cnt == 2'd3;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = m.miss_valid ? REQ : IDLE;
      REQ:      nxt = m.l1tol2_req_retry ? REQ : WAIT_ACK;
      WAIT_ACK: nxt = ack_ok ? VICTIM : WAIT_ACK;
      VICTIM:   nxt = !leave ? VICTIM : m.set_dirty[vw] ? DISP : FILL;
      DISP:     nxt = m.l1tol2_disp_retry ? DISP : FILL;
      FILL:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tag_q <= '0;
      idx_q <= '0;
      wr_q <= 1'b0;
      st_q <= ST_I;
      way_q <= '0;
      age_cnt <= '0;
    end else begin
      if (state == IDLE && m.miss_valid) begin
        tag_q <= m.miss_tag;
        idx_q <= m.miss_index;
        wr_q <= m.miss_write;
        age_cnt <= '0;
      end
      if (state == WAIT_ACK && ack_ok) st_q <= ack_st;
      if (m.age_valid) age_cnt <= age_cnt + 2'd1;
      if (state == VICTIM && leave) way_q <= vw;
    end
  assign m.miss_retry = state != IDLE;
  assign m.busy = state != IDLE;
  assign m.l1tol2_req_valid = state == REQ;
  assign m.l1tol2_req = state == REQ ? (wr_q ? REQ_M : REQ_S) : 3'd0;
  assign m.l1tol2_disp_valid = state == DISP;
  assign m.l1tol2_disp = state == DISP ? DISP_CMD : 3'd0;
  assign m.age_valid = state == VICTIM && !leave;
  assign m.age_rrip = m.age_valid ? age_next : '0;
  assign m.fill_valid = state == FILL;
  assign m.fill_index = m.fill_valid ? idx_q : '0;
  assign m.fill_way = m.fill_valid ? way_q : '0;
  assign m.fill_data = m.fill_valid ? {st_q, RRIP_INS, tag_q} : '0;
endmodule

// File: tb/tb_dc_1_missctl.sv
// tb_dc_1_missctl: directed and randomized misses against a per-transaction outcome model
module tb_dc_1_missctl;
  localparam logic [2:0] REQ_S = 3'd1, REQ_M = 3'd2;
  localparam logic [4:0] ACK_S = 5'h04, ACK_E = 5'h05, ACK_M = 5'h06;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int ncmp = 0;
  int nerr = 0;
  dc_1_missctl_if m ();
  dc_1_missctl dut (.clk(clk), .reset(reset), .m(m.master));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0h exp=%0h", t, got, exp);
    end
  endtask
  // tag bank view after k aging writes: every counter advanced k, clipped at 3
  function automatic logic [15:0] sat(input logic [15:0] r, input int k);
    logic [15:0] o;
    int c;
    o = '0;
    for (int w = 0; w < 8; w++) begin
      c = int'(r[2*w+:2]) + k;
      o[2*w+:2] = 2'(c > 3 ? 3 : c);
    end
    return o;
  endfunction
  task automatic run_miss(input logic [9:0] tag, input logic [4:0] idx, input logic wr,
                          input logic [4:0] ack, input int ackd, input int rqr, input int dsr,
                          input logic [15:0] rrip, input logic [7:0] dirty, input logic keep);
    int mx, ages, vway;
    logic [15:0] cur, e;
    logic [2:0] st;
    logic [4:0] junk [3];
    junk = '{5'h00, 5'h07, 5'h1f};
    mx = 0;
    for (int w = 0; w < 8; w++) if (int'(rrip[2*w+:2]) > mx) mx = int'(rrip[2*w+:2]);
    ages = 3 - mx;
    vway = 0;
    for (int w = 7; w >= 0; w--) if (int'(rrip[2*w+:2]) == mx) vway = w;
    st = ack == ACK_S ? 3'd1 : ack == ACK_E ? 3'd2 : 3'd3;
    m.set_rrip = rrip;
    m.set_dirty = dirty;
    m.miss_valid = 1'b1;
    m.miss_tag = tag;
    m.miss_index = idx;
    m.miss_write = wr;
    #1;
    chk("idle_retry", m.miss_retry, 0);
    chk("idle_busy", m.busy, 0);
    tick;
    if (!keep) m.miss_valid = 1'b0;
    for (int i = 0; i <= rqr; i++) begin
      m.l1tol2_req_retry = i < rqr;
      m.l2tol1_snack_valid = 1'($urandom_range(0, 1));
      m.l2tol1_snack = ACK_M;
      #1;
      chk("req_valid", m.l1tol2_req_valid, 1);
      chk("req_cmd", m.l1tol2_req, wr ? REQ_M : REQ_S);
      chk("busy_retry", {m.busy, m.miss_retry}, 2'b11);
      tick;
    end
    m.l1tol2_req_retry = 1'b0;
    for (int i = 0; i < ackd; i++) begin
      m.l2tol1_snack_valid = 1'($urandom_range(0, 1));
      m.l2tol1_snack = junk[$urandom_range(0, 2)];
      #1;
      chk("wait_noreq", m.l1tol2_req_valid, 0);
      chk("wait_nofill", m.fill_valid, 0);
      chk("wait_retry", m.miss_retry, 1);
      tick;
    end
    m.l2tol1_snack_valid = 1'b1;
    m.l2tol1_snack = ack;
    #1;
    chk("ack_noreq", m.l1tol2_req_valid, 0);
    tick;
    m.l2tol1_snack_valid = 1'b0;
    cur = rrip;
    for (int k = 1; k <= ages; k++) begin
      m.set_rrip = cur;
      e = sat(rrip, k);
      #1;
      chk("age_valid", m.age_valid, 1);
      chk("age_rrip", m.age_rrip, e);
      tick;
      cur = e;
    end
    m.set_rrip = cur;
    #1;
    chk("victim_noage", m.age_valid, 0);
    chk("victim_nofill", m.fill_valid, 0);
    tick;
    if (dirty[vway]) begin
      for (int i = 0; i <= dsr; i++) begin
        m.l1tol2_disp_retry = i < dsr;
        #1;
        chk("disp_valid", m.l1tol2_disp_valid, 1);
        chk("disp_cmd", m.l1tol2_disp, 3'b001);
        tick;
      end
      m.l1tol2_disp_retry = 1'b0;
    end
    #1;
    chk("fill_valid", m.fill_valid, 1);
    chk("fill_index", m.fill_index, idx);
    chk("fill_way", m.fill_way, vway);
    chk("fill_data", m.fill_data, {st, 2'd2, tag});
    chk("fill_nodisp", m.l1tol2_disp_valid, 0);
    tick;
    #1;
    chk("post_nofill", m.fill_valid, 0);
    chk("post_busy", m.busy, 0);
    chk("post_retry", m.miss_retry, 0);
  endtask
  initial begin
    m.miss_valid = 1'b0;
    m.miss_write = 1'b0;
    m.miss_tag = '0;
    m.miss_index = '0;
    m.set_rrip = '0;
    m.set_dirty = '0;
    m.l1tol2_req_retry = 1'b0;
    m.l2tol1_snack_valid = 1'b0;
    m.l2tol1_snack = '0;
    m.l1tol2_disp_retry = 1'b0;
    tick;
    tick;
    chk("rst_busy", m.busy, 0);
    chk("rst_retry", m.miss_retry, 0);
    chk("rst_req", {m.l1tol2_req_valid, m.l1tol2_req}, 0);
    chk("rst_disp", {m.l1tol2_disp_valid, m.l1tol2_disp}, 0);
    chk("rst_age", {m.age_valid, m.age_rrip}, 0);
    chk("rst_fill", {m.fill_valid, m.fill_index, m.fill_way, m.fill_data}, 0);
    #3 reset = 1'b1;
    tick;
    run_miss(10'h155, 5'd3, 1'b0, ACK_E, 4, 0, 0, 16'h0030, 8'h00, 1'b0);
    run_miss(10'h2a7, 5'd17, 1'b1, ACK_M, 2, 5, 0, 16'hc000, 8'h00, 1'b0);
    run_miss(10'h0f0, 5'd8, 1'b0, ACK_S, 1, 0, 0, 16'h0000, 8'h00, 1'b0);
    run_miss(10'h3c1, 5'd30, 1'b1, ACK_S, 0, 1, 2, 16'h0c16, 8'h20, 1'b0);
    run_miss(10'h111, 5'd5, 1'b1, ACK_E, 3, 0, 0, 16'h5003, 8'h00, 1'b1);
    run_miss(10'h111, 5'd5, 1'b1, ACK_M, 1, 0, 0, 16'h0300, 8'h00, 1'b0);
    for (int n = 0; n < 20; n++) begin
      logic [4:0] a;
      a = n % 3 == 0 ? ACK_S : n % 3 == 1 ? ACK_E : ACK_M;
      run_miss(10'($urandom), 5'($urandom), 1'($urandom), a, $urandom_range(0, 5),
               $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom), 8'($urandom), 1'b0);
    end
    m.miss_valid = 1'b1;
    m.miss_tag = 10'h0aa;
    m.miss_index = 5'd9;
    m.miss_write = 1'b0;
    tick;
    m.miss_valid = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    #1;
    chk("arst_busy", m.busy, 0);
    chk("arst_req", m.l1tol2_req_valid, 0);
    chk("arst_retry", m.miss_retry, 0);
    chk("arst_fill", m.fill_valid, 0);
    #5 reset = 1'b1;
    tick;
    m.l2tol1_snack_valid = 1'b1;
    m.l2tol1_snack = ACK_S;
    tick;
    m.l2tol1_snack_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("late_ack_nofill", m.fill_valid, 0);
      chk("late_ack_idle", m.busy, 0);
      tick;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
